// File: rtl/csc_lct_to_gem_window.sv
// Projects CSC LCT keys (wiregroup + 1/8-strip xky) into GEM roll/pad search windows.
// LCTs queue in a small FIFO, then flow through two arithmetic stages to a valid/ready output.
module csc_lct_to_gem_window #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned MAXWIRE      = 47,
    parameter int unsigned MAXPAD       = 191,
    parameter int unsigned ME1A_XKY_MIN = 512,
    parameter logic [48:0] ROLL_EDGES   = {7'd42, 7'd36, 7'd30, 7'd24, 7'd18, 7'd12, 7'd6}
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       evenchamber,
    input  logic       gem_match_enable,
    input  logic [4:0] gem_deltapad,
    input  logic [2:0] gem_deltawire,
    input  logic       lct0_vpf,
    input  logic [9:0] lct0_xky,
    input  logic [6:0] lct0_wire,
    input  logic       lct1_vpf,
    input  logic [9:0] lct1_xky,
    input  logic [6:0] lct1_wire,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_lctidx,
    output logic       out_me1a,
    output logic [2:0] out_roll_lo,
    output logic [2:0] out_roll_hi,
    output logic [7:0] out_pad_lo,
    output logic [7:0] out_pad_hi,
    output logic       fifo_overflow,
    output logic [7:0] drop_count
);
    localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW     = PW + 1;
    localparam int STAGES = 2;

    typedef struct packed {
        logic       idx;
        logic [9:0] xky;
        logic [6:0] wg;
    } lct_entry_t;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    lct_entry_t mem [FIFO_DEPTH];
    lct_entry_t head, e0, e1, wr_e0, wr_e1;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, free;
    logic [1:0]    push_cnt, drop_cnt;
    logic          adv, pop, empty;
    logic [STAGES:0] vld_pipe;
    state_t        state, state_nxt;

    // stage A / B registers
    logic       a_idx, a_me1a, b_idx, b_me1a;
    logic [7:0] a_c, b_plo, b_phi;
    logic [6:0] a_wlo, a_whi;
    logic [2:0] b_rlo, b_rhi;

    // stage A / B combinational results
    logic       sa_me1a;
    logic [7:0] sa_c, sa_c_a, sa_c_b;
    logic [6:0] sa_wlo, sa_whi;
    logic [7:0] sa_wsum;
    logic [7:0] sb_plo, sb_phi;
    logic [8:0] sb_psum;

    function automatic logic [2:0] roll_of(input logic [6:0] w);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 0; k < 7; k++)
            if (w >= ROLL_EDGES[7*k +: 7]) r = r + 3'd1;
        return r;
    endfunction

    assign e0    = '{idx: 1'b0, xky: lct0_xky, wg: lct0_wire};
    assign e1    = '{idx: 1'b1, xky: lct1_xky, wg: lct1_wire};
    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign out_valid = vld_pipe[STAGES];
    assign adv   = !out_valid || out_ready;
    assign pop   = adv && !empty;

    // Space is judged after this cycle's pop; LCT0 wins a single free slot.
    always_comb begin
        free     = CW'(FIFO_DEPTH) - count + CW'(pop);
        push_cnt = 2'd0;
        drop_cnt = 2'd0;
        wr_e0    = e0;
        wr_e1    = e1;
        if (gem_match_enable) begin
            if (lct0_vpf && lct1_vpf) begin
                if (free >= CW'(2))      push_cnt = 2'd2;
                else if (free != '0)     begin push_cnt = 2'd1; drop_cnt = 2'd1; end
                else                     drop_cnt = 2'd2;
            end else if (lct0_vpf || lct1_vpf) begin
                wr_e0 = lct0_vpf ? e0 : e1;
                if (free != '0) push_cnt = 2'd1;
                else            drop_cnt = 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_cnt != 2'd0) mem[wr_ptr] <= wr_e0;
        if (push_cnt == 2'd2) mem[wr_ptr + PW'(1)] <= wr_e1;
    end

    always_comb begin
        sa_me1a = head.xky >= 10'(ME1A_XKY_MIN);
        sa_c_b  = 8'((12'(head.xky) * 12'd3) >> 3);
        sa_c_a  = 8'((head.xky - 10'(ME1A_XKY_MIN)) >> 1);
        if (sa_c_a > 8'(MAXPAD)) sa_c_a = 8'(MAXPAD);
        sa_c    = sa_me1a ? sa_c_a : sa_c_b;
        if (!evenchamber) sa_c = 8'(MAXPAD) - sa_c;
        sa_wlo  = (head.wg >= 7'(gem_deltawire)) ? head.wg - 7'(gem_deltawire) : 7'd0;
        sa_wsum = 8'(head.wg) + 8'(gem_deltawire);
        sa_whi  = (sa_wsum > 8'(MAXWIRE)) ? 7'(MAXWIRE) : sa_wsum[6:0];
    end

    always_comb begin
        sb_plo  = (a_c >= 8'(gem_deltapad)) ? a_c - 8'(gem_deltapad) : 8'd0;
        sb_psum = 9'(a_c) + 9'(gem_deltapad);
        sb_phi  = (sb_psum > 9'(MAXPAD)) ? 8'(MAXPAD) : sb_psum[7:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0; wr_ptr <= '0; count <= '0;
            vld_pipe <= '0;
            a_idx <= 1'b0; a_me1a <= 1'b0; a_c <= '0; a_wlo <= '0; a_whi <= '0;
            b_idx <= 1'b0; b_me1a <= 1'b0; b_rlo <= '0; b_rhi <= '0; b_plo <= '0; b_phi <= '0;
            out_lctidx <= 1'b0; out_me1a <= 1'b0;
            out_roll_lo <= '0; out_roll_hi <= '0; out_pad_lo <= '0; out_pad_hi <= '0;
            fifo_overflow <= 1'b0; drop_count <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            wr_ptr <= wr_ptr + PW'(push_cnt);
            count  <= count + CW'(push_cnt) - CW'(pop);
            if (drop_cnt != 2'd0) begin
                fifo_overflow <= 1'b1;
                drop_count    <= ({1'b0, drop_count} + 9'(drop_cnt) > 9'd255) ? 8'hff
                                 : drop_count + 8'(drop_cnt);
            end
            if (adv) begin
                vld_pipe <= {vld_pipe[STAGES-1:0], !empty};
                if (!empty) begin
                    a_idx <= head.idx; a_me1a <= sa_me1a; a_c <= sa_c;
                    a_wlo <= sa_wlo;   a_whi <= sa_whi;
                end
                b_idx  <= a_idx;
                b_me1a <= a_me1a;
                b_rlo  <= a_me1a ? 3'd7 : roll_of(a_wlo);
                b_rhi  <= a_me1a ? 3'd7 : roll_of(a_whi);
                b_plo  <= sb_plo;
                b_phi  <= sb_phi;
                out_lctidx  <= b_idx;  out_me1a    <= b_me1a;
                out_roll_lo <= b_rlo;  out_roll_hi <= b_rhi;
                out_pad_lo  <= b_plo;  out_pad_hi  <= b_phi;
            end
        end
    end

    // Status-only FSM; the datapath never looks at it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (push_cnt != 2'd0) state_nxt = RUN;
            RUN: begin
                if (out_valid && !out_ready) state_nxt = HOLD;
                else if (empty && vld_pipe == '0 && push_cnt == 2'd0) state_nxt = IDLE;
            end
            HOLD: if (out_ready) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_csc_lct_to_gem_window.sv
// Bench for csc_lct_to_gem_window: directed windows, overflow, async reset and random
// traffic checked cycle by cycle against a queue-based behavioural model.
module tb_csc_lct_to_gem_window;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       evenchamber = 1'b1, gem_match_enable = 1'b0;
    logic [4:0] gem_deltapad = '0;
    logic [2:0] gem_deltawire = '0;
    logic       lct0_vpf = 1'b0, lct1_vpf = 1'b0;
    logic [9:0] lct0_xky = '0, lct1_xky = '0;
    logic [6:0] lct0_wire = '0, lct1_wire = '0;
    logic       out_ready = 1'b1;
    logic       out_valid, out_lctidx, out_me1a, fifo_overflow;
    logic [2:0] out_roll_lo, out_roll_hi;
    logic [7:0] out_pad_lo, out_pad_hi, drop_count;

    csc_lct_to_gem_window dut (
        .clock(clock), .reset_n(reset_n), .evenchamber(evenchamber),
        .gem_match_enable(gem_match_enable), .gem_deltapad(gem_deltapad),
        .gem_deltawire(gem_deltawire),
        .lct0_vpf(lct0_vpf), .lct0_xky(lct0_xky), .lct0_wire(lct0_wire),
        .lct1_vpf(lct1_vpf), .lct1_xky(lct1_xky), .lct1_wire(lct1_wire),
        .out_valid(out_valid), .out_ready(out_ready), .out_lctidx(out_lctidx),
        .out_me1a(out_me1a), .out_roll_lo(out_roll_lo), .out_roll_hi(out_roll_hi),
        .out_pad_lo(out_pad_lo), .out_pad_hi(out_pad_hi),
        .fifo_overflow(fifo_overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct { int idx; int xky; int wg; } lct_t;
    typedef struct { bit vld; int idx; int me1a; int rlo; int rhi; int plo; int phi; } win_t;

    lct_t q[$];
    win_t slot[3];
    int   m_drops;
    bit   m_ovf;
    int   n_assert = 0, n_fail = 0;

    function automatic int roll(int w);
        int edges[7] = '{6, 12, 18, 24, 30, 36, 42};
        int r = 0;
        foreach (edges[k]) if (w >= edges[k]) r++;
        return r;
    endfunction

    function automatic win_t make_win(lct_t e, bit even, int dp, int dw);
        win_t w;
        int c, wl, wh;
        w.vld  = 1'b1;
        w.idx  = e.idx;
        w.me1a = (e.xky >= 512) ? 1 : 0;
        if (w.me1a != 0) begin
            c = (e.xky - 512) / 2;
            if (c > 191) c = 191;
        end else c = (e.xky * 3) / 8;
        if (!even) c = 191 - c;
        wl = (e.wg - dw < 0) ? 0 : e.wg - dw;
        wh = (e.wg + dw > 47) ? 47 : e.wg + dw;
        w.plo = (c - dp < 0) ? 0 : c - dp;
        w.phi = (c + dp > 191) ? 191 : c + dp;
        w.rlo = (w.me1a != 0) ? 7 : roll(wl);
        w.rhi = (w.me1a != 0) ? 7 : roll(wh);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        foreach (slot[i]) slot[i].vld = 1'b0;
        m_drops = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        bit adv;
        int free, drops;
        @(posedge clock);
        adv = !slot[2].vld || out_ready;
        if (adv) begin
            slot[2] = slot[1];
            slot[1] = slot[0];
            slot[0].vld = 1'b0;
            if (q.size() > 0)
                slot[0] = make_win(q.pop_front(), evenchamber, int'(gem_deltapad), int'(gem_deltawire));
        end
        free  = DEPTH - q.size();
        drops = 0;
        if (gem_match_enable) begin
            if (lct0_vpf) begin
                if (free > 0) begin q.push_back('{0, int'(lct0_xky), int'(lct0_wire)}); free--; end
                else drops++;
            end
            if (lct1_vpf) begin
                if (free > 0) begin q.push_back('{1, int'(lct1_xky), int'(lct1_wire)}); free--; end
                else drops++;
            end
        end
        m_drops = (m_drops + drops > 255) ? 255 : m_drops + drops;
        if (drops > 0) m_ovf = 1'b1;
        #1;
        chk("out_valid", 32'(out_valid), 32'(slot[2].vld));
        if (slot[2].vld) begin
            chk("lctidx",  32'(out_lctidx),  32'(slot[2].idx));
            chk("me1a",    32'(out_me1a),    32'(slot[2].me1a));
            chk("roll_lo", 32'(out_roll_lo), 32'(slot[2].rlo));
            chk("roll_hi", 32'(out_roll_hi), 32'(slot[2].rhi));
            chk("pad_lo",  32'(out_pad_lo),  32'(slot[2].plo));
            chk("pad_hi",  32'(out_pad_hi),  32'(slot[2].phi));
        end
        chk("drop_count", 32'(drop_count), 32'(m_drops));
        chk("overflow",   32'(fifo_overflow), 32'(m_ovf));
    endtask

    task automatic direct(input string tag, input int xky, input int wg, input bit even,
                          input int dp, input int dw, input int rlo, input int rhi,
                          input int plo, input int phi, input int me1a);
        evenchamber   = even;
        gem_deltapad  = 5'(dp);
        gem_deltawire = 3'(dw);
        lct0_vpf = 1'b1; lct0_xky = 10'(xky); lct0_wire = 7'(wg);
        step();
        lct0_vpf = 1'b0;
        step();
        step();
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, "_valid"},   32'(out_valid),   32'd1);
        chk({tag, "_idx"},     32'(out_lctidx),  32'd0);
        chk({tag, "_me1a"},    32'(out_me1a),    32'(me1a));
        chk({tag, "_roll_lo"}, 32'(out_roll_lo), 32'(rlo));
        chk({tag, "_roll_hi"}, 32'(out_roll_hi), 32'(rhi));
        chk({tag, "_pad_lo"},  32'(out_pad_lo),  32'(plo));
        chk({tag, "_pad_hi"},  32'(out_pad_hi),  32'(phi));
        step();
        step();
    endtask

    initial begin
        model_clear();
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pad_lo", 32'(out_pad_lo), 32'd0);
        chk("rst_pad_hi", 32'(out_pad_hi), 32'd0);
        chk("rst_roll_hi", 32'(out_roll_hi), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_ovf", 32'(fifo_overflow), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        gem_match_enable = 1'b1;
        out_ready = 1'b1;

        direct("even_me1b", 256, 20, 1'b1, 4, 2, 3, 3, 92, 100, 0);
        direct("odd_me1b",  256, 20, 1'b0, 4, 2, 3, 3, 91, 99, 0);
        direct("me1a_sat",  895, 45, 1'b1, 8, 2, 7, 7, 183, 191, 1);
        direct("low_sat",   0, 1, 1'b1, 31, 7, 0, 1, 0, 31, 0);

        // Back-to-back pair: LCT1 follows LCT0 by one cycle.
        lct0_vpf = 1'b1; lct0_xky = 10'd100; lct0_wire = 7'd10;
        lct1_vpf = 1'b1; lct1_xky = 10'd600; lct1_wire = 7'd30;
        step();
        lct0_vpf = 1'b0; lct1_vpf = 1'b0;
        repeat (5) step();

        // Stall with both LCTs every cycle: fill, then drop.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            lct0_vpf = 1'b1; lct0_xky = 10'(40 * i); lct0_wire = 7'(5 + i);
            lct1_vpf = 1'b1; lct1_xky = 10'(520 + 30 * i); lct1_wire = 7'(20 + i);
            step();
        end
        chk("ovf_drop_count", 32'(drop_count), 32'd5);
        chk("ovf_sticky", 32'(fifo_overflow), 32'd1);
        chk("ovf_held_valid", 32'(out_valid), 32'd1);
        lct0_vpf = 1'b0; lct1_vpf = 1'b0;
        step();

        // Async reset while a window is held.
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_drops", 32'(drop_count), 32'd0);
        chk("arst_ovf", 32'(fifo_overflow), 32'd0);
        model_clear();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();

        for (int p = 0; p < 3; p++) begin
            gem_deltapad  = 5'($urandom_range(0, 31));
            gem_deltawire = 3'($urandom_range(0, 7));
            for (int i = 0; i < 120; i++) begin
                gem_match_enable = ($urandom_range(0, 7) != 0);
                lct0_vpf  = 1'($urandom_range(0, 1));
                lct0_xky  = 10'($urandom_range(0, 1023));
                lct0_wire = 7'($urandom_range(0, 63));
                lct1_vpf  = 1'($urandom_range(0, 1));
                lct1_xky  = 10'($urandom_range(0, 1023));
                lct1_wire = 7'($urandom_range(0, 63));
                out_ready = ($urandom_range(0, 3) != 0);
                evenchamber = 1'($urandom_range(0, 1));
                step();
            end
            gem_match_enable = 1'b0;
            out_ready = 1'b1;
            repeat (8) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
